// File: rtl/miner_nonce_sequencer.sv
// miner_nonce_sequencer
//   Walks a 32-bit nonce range, issuing one request at a time to a hash core
//   and stopping on the first digest with cfg_difficulty leading zero bits.
// Ports:
//   clock, resetb          : clock, async active-low reset
//   cfg_start / cfg_abort  : one-cycle control pulses (abort has priority)
//   cfg_nonce_start/_end   : inclusive nonce range, cfg_difficulty: leading zeros
//   hash_req_*             : valid/ready nonce request to the hash core
//   hash_rsp_*             : one-cycle digest strobe from the hash core
//   busy, done, found, found_nonce, hash_count : search status
//   status                 : {8'hAB, state code} for GPIO observation
module miner_nonce_sequencer #(
  parameter int unsigned DIGEST_W = 256
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [31:0]         cfg_nonce_start,
  input  logic [31:0]         cfg_nonce_end,
  input  logic [7:0]          cfg_difficulty,
  output logic                hash_req_valid,
  output logic [31:0]         hash_req_nonce,
  input  logic                hash_req_ready,
  input  logic                hash_rsp_valid,
  input  logic [DIGEST_W-1:0] hash_rsp_digest,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [31:0]         found_nonce,
  output logic [31:0]         hash_count,
  output logic [15:0]         status
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

  state_e              r_state,       w_state_nxt;
  logic [31:0]         r_nonce,       w_nonce_nxt;
  logic [31:0]         r_end,         w_end_nxt;
  logic [7:0]          r_diff,        w_diff_nxt;
  logic [DIGEST_W-1:0] r_digest,      w_digest_nxt;
  logic                r_found,       w_found_nxt;
  logic [31:0]         r_found_nonce, w_found_nonce_nxt;
  logic [31:0]         r_count,       w_count_nxt;
  logic                r_done,        w_done_nxt;
  logic                w_match;

  // Match when the top r_diff digest bits (MSB first) are all zero.
  always_comb begin
    w_match = 1'b1;
    for (int unsigned i = 0; i < DIGEST_W; i++) begin
      if ((i < 32'(r_diff)) && r_digest[DIGEST_W-1-i]) begin
        w_match = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_nonce_nxt       = r_nonce;
    w_end_nxt         = r_end;
    w_diff_nxt        = r_diff;
    w_digest_nxt      = r_digest;
    w_found_nxt       = r_found;
    w_found_nonce_nxt = r_found_nonce;
    w_count_nxt       = r_count;
    w_done_nxt        = 1'b0;
    if (cfg_abort) begin
      // hash_count deliberately held so software can read partial progress
      w_state_nxt       = StIdle;
      w_found_nxt       = 1'b0;
      w_found_nonce_nxt = '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (cfg_start) begin
            w_nonce_nxt       = cfg_nonce_start;
            w_end_nxt         = cfg_nonce_end;
            w_diff_nxt        = cfg_difficulty;
            w_found_nxt       = 1'b0;
            w_found_nonce_nxt = '0;
            w_count_nxt       = '0;
            if (cfg_nonce_start > cfg_nonce_end) begin
              w_state_nxt = StDone;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = StIssue;
            end
          end
        end
        StIssue: begin
          if (hash_req_ready) w_state_nxt = StWait;
        end
        StWait: begin
          if (hash_rsp_valid) begin
            w_digest_nxt = hash_rsp_digest;
            w_state_nxt  = StCheck;
          end
        end
        StCheck: begin
          w_count_nxt = (r_count == '1) ? r_count : r_count + 32'd1;
          if (w_match) begin
            w_found_nxt       = 1'b1;
            w_found_nonce_nxt = r_nonce;
            w_state_nxt       = StDone;
            w_done_nxt        = 1'b1;
          end else if (r_nonce == r_end) begin
            // end-of-range test precedes increment so the nonce never wraps
            w_state_nxt = StDone;
            w_done_nxt  = 1'b1;
          end else begin
            w_nonce_nxt = r_nonce + 32'd1;
            w_state_nxt = StIssue;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= StIdle;
      r_nonce       <= '0;
      r_end         <= '0;
      r_diff        <= '0;
      r_digest      <= '0;
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_nonce       <= w_nonce_nxt;
      r_end         <= w_end_nxt;
      r_diff        <= w_diff_nxt;
      r_digest      <= w_digest_nxt;
      r_found       <= w_found_nxt;
      r_found_nonce <= w_found_nonce_nxt;
      r_count       <= w_count_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    status = 16'hAB40;
    unique case (r_state)
      StIdle:  status = 16'hAB40;
      StIssue: status = 16'hAB41;
      StWait:  status = 16'hAB42;
      StCheck: status = 16'hAB43;
      StDone:  status = r_found ? 16'hAB51 : 16'hAB50;
      default: status = 16'hAB40;
    endcase
  end

  assign hash_req_valid = (r_state == StIssue);
  assign hash_req_nonce = r_nonce;
  assign busy           = (r_state == StIssue) || (r_state == StWait) || (r_state == StCheck);
  assign done           = r_done;
  assign found          = r_found;
  assign found_nonce    = r_found_nonce;
  assign hash_count     = r_count;

endmodule
